sum_deserializer: RTL and testbench
===================================

SUM_DESERIALIZER -- requirements
Module: sum_deserializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of sum bits per frame (legal range 2..32).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a new frame; honoured in IDLE only, and in HOLD on the handshake cycle (REQ-014).
REQ-005 abort  input  1  discard the frame in progress.
REQ-006 bit_vld  input  1  S_in/COUT_in carry a valid bit this cycle.
REQ-007 S_in  input  1  serial sum bit, LSB first.
REQ-008 COUT_in  input  1  serial carry bit; only the value on the last bit of a frame is kept.
REQ-009 out_rdy  input  1  downstream accepts the result.
REQ-010 SUM  output  WIDTH  assembled sum word, registered.
REQ-011 CARRY  output  1  final carry of the frame, registered.
REQ-012 out_vld  output  1  SUM/CARRY valid, held until accepted.
REQ-013 busy  output  1  high in COLLECT.

Function
REQ-014 FSM states: IDLE, COLLECT, HOLD.
- IDLE->COLLECT on start.
- COLLECT->HOLD on accepted last bit (bit_vld with bit count = WIDTH-1).
- COLLECT->IDLE on abort.
- HOLD->IDLE on out_vld&&out_rdy, or HOLD->COLLECT if start is high in that same cycle.
REQ-015 Entering COLLECT: bit counter and shift register SHALL clear to 0.
REQ-016 Each cycle in COLLECT with bit_vld=1: S_in SHALL shift into the MSB with right-shift, so the first bit ends at SUM[0]; counter increments by 1.
REQ-017 Cycles in COLLECT with bit_vld=0 SHALL leave the shift register and counter unchanged.
REQ-018 On the last bit, the shift result SHALL load into SUM and COUT_in into CARRY; out_vld SHALL rise on that same edge, giving 1 cycle latency from last-bit sample to out_vld visible.
REQ-019 SUM, CARRY and out_vld SHALL be stable throughout HOLD, regardless of bit_vld, S_in and abort.
REQ-020 out_vld SHALL deassert on the edge following the out_vld&&out_rdy cycle.
REQ-021 In HOLD, bit_vld SHALL be ignored; bits are not buffered.
REQ-022 abort with bit_vld in the same COLLECT cycle: abort wins, the bit is dropped and SUM/CARRY are not updated.
REQ-023 abort on the last-bit cycle: the frame is discarded and out_vld stays 0.
REQ-024 start while in COLLECT SHALL be ignored; the frame continues.
REQ-025 bit_vld, abort and out_rdy in IDLE SHALL have no effect.
REQ-026 The counter SHALL be ceil(log2(WIDTH)) bits and never wrap within a frame; it resets to 0 on each new frame.
REQ-027 busy = (state == COLLECT), decoded from the state register.

Reset
REQ-028 RST high SHALL immediately force: state IDLE, counter 0, shift register 0, SUM=0, CARRY=0, out_vld=0, busy=0.
REQ-029 Reset mid-COLLECT or mid-HOLD SHALL discard all frame data; no out_vld pulse on or after release.
REQ-030 First start is honoured on the first rising edge after RST falls.

Verification
REQ-031 WIDTH=8, start, then bits 1,0,1,0,0,1,0,1 back-to-back with COUT_in=1 on the last bit, out_rdy=1 -> SUM=0xA5, CARRY=1, out_vld high exactly 1 cycle, then IDLE.
REQ-032 Same frame with bit_vld gaps of 3 idle cycles between bits -> SUM=0xA5; out_vld rises 1 cycle after the 8th valid bit; busy high throughout.
REQ-033 Frame 0xFF, CARRY=0, out_rdy=0 for 5 cycles -> out_vld, SUM=0xFF and CARRY held for all 5 cycles; extra bit_vld pulses in HOLD do not change SUM.
REQ-034 abort after 4 bits, then new frame 0x3C -> no out_vld for the aborted frame; result SUM=0x3C.
REQ-035 RST pulse after 6 bits -> all outputs 0 immediately; next full frame 0x81 yields SUM=0x81.
REQ-036 HOLD with out_rdy=1 and start=1 in the same cycle, next frame 0x5A -> direct HOLD->COLLECT with no IDLE cycle; second result SUM=0x5A.

Source files
------------

// File: rtl/sum_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sum_deserializer_if
//  Purpose  : Serial-bit input side and parallel result side of the sum
//             deserializer, grouped so the source and the block share a
//             single connection.
//  Revision : 1.0  initial release
// ============================================================================
interface sum_deserializer_if #(
  parameter int WIDTH = 8
);

  // Frame control and serial bit stream
  logic             start;
  logic             abort;
  logic             bit_vld;
  logic             S_in;
  logic             COUT_in;

  // Result handshake
  logic             out_rdy;
  logic [WIDTH-1:0] SUM;
  logic             CARRY;
  logic             out_vld;
  logic             busy;

  // Bit source / result consumer side
  modport master (
    output start, abort, bit_vld, S_in, COUT_in, out_rdy,
    input  SUM, CARRY, out_vld, busy
  );

  // Deserializer side
  modport slave (
    input  start, abort, bit_vld, S_in, COUT_in, out_rdy,
    output SUM, CARRY, out_vld, busy
  );

endinterface
`default_nettype wire

// File: rtl/sum_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : sum_deserializer
//  Purpose  : Collects a serial sum (LSB first) plus its final carry into a
//             WIDTH-bit word and presents it with a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module sum_deserializer #(
  parameter int WIDTH = 8
) (
  input  wire logic          CLK,
  input  wire logic          RST,
  sum_deserializer_if.slave  bus
);

  // Counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_out_vld;

  logic [WIDTH-1:0]   w_shift_next;
  logic               w_last_bit;
  logic               w_take_bit;
  logic               w_handshake;

  // Right shift with the new bit entering at the MSB: after WIDTH bits the
  // first bit received has walked down to bit 0.
  assign w_shift_next = {bus.S_in, r_shift[WIDTH-1:1]};
  assign w_last_bit   = (r_count == c_LAST);

  // abort has priority over a bit arriving in the same cycle.
  assign w_take_bit   = bus.bit_vld && !bus.abort;
  assign w_handshake  = r_out_vld && bus.out_rdy;

  // Frame state machine, bit collection and registered result outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_shift   <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // bit_vld, abort and out_rdy are meaningless until a frame starts.
          if (bus.start) begin
            r_state <= S_COLLECT;
            r_count <= '0;
            r_shift <= '0;
          end
        end

        S_COLLECT: begin
          // start is ignored here; the current frame keeps running.
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else if (w_take_bit) begin
            r_shift <= w_shift_next;
            if (w_last_bit) begin
              r_sum     <= w_shift_next;
              r_carry   <= bus.COUT_in;
              r_out_vld <= 1'b1;
              r_state   <= S_HOLD;
            end else begin
              r_count <= r_count + c_ONE;
            end
          end
        end

        S_HOLD: begin
          // Result is frozen; incoming bits and abort are not looked at.
          if (w_handshake) begin
            r_out_vld <= 1'b0;
            if (bus.start) begin
              // Back-to-back frame: skip IDLE entirely.
              r_state <= S_COLLECT;
              r_count <= '0;
              r_shift <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_out_vld <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from registers; busy is a decode of the state.
  assign bus.SUM     = r_sum;
  assign bus.CARRY   = r_carry;
  assign bus.out_vld = r_out_vld;
  assign bus.busy    = (r_state == S_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_sum_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sum_deserializer
//  Purpose  : Self-checking bench for sum_deserializer (WIDTH = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sum_deserializer;

  localparam int WIDTH = 8;

  logic CLK;
  logic RST;

  sum_deserializer_if #(.WIDTH(WIDTH)) bus ();

  sum_deserializer #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model (frame-level view) ----------------
  // m_mode: 0 waiting for start, 1 gathering bits, 2 result on offer
  int               m_mode;
  bit               m_bits[$];
  logic [WIDTH-1:0] m_sum;
  logic             m_carry;
  logic             m_vld;

  function automatic void model_reset();
    m_mode  = 0;
    m_bits.delete();
    m_sum   = '0;
    m_carry = 1'b0;
    m_vld   = 1'b0;
  endfunction

  function automatic void model_step(logic st, logic ab, logic bv, logic s,
                                     logic c, logic rdy);
    int value;
    case (m_mode)
      0: if (st) begin m_mode = 1; m_bits.delete(); end
      1: begin
        if (ab) m_mode = 0;
        else if (bv) begin
          m_bits.push_back(s);
          if (m_bits.size() == WIDTH) begin
            value = 0;
            foreach (m_bits[i]) value = value + int'(m_bits[i]) * (1 << i);
            m_sum   = WIDTH'(value);
            m_carry = c;
            m_vld   = 1'b1;
            m_mode  = 2;
          end
        end
      end
      default: begin
        if (rdy) begin
          m_vld = 1'b0;
          m_mode = st ? 1 : 0;
          m_bits.delete();
        end
      end
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_model(input string name);
    check(name, {21'd0, bus.SUM, bus.CARRY, bus.out_vld, bus.busy},
                {21'd0, m_sum, m_carry, m_vld, (m_mode == 1)});
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle.
  task automatic cyc(input logic st, input logic ab, input logic bv,
                     input logic s, input logic c, input logic rdy);
    bus.start = st; bus.abort = ab; bus.bit_vld = bv;
    bus.S_in = s; bus.COUT_in = c; bus.out_rdy = rdy;
    @(posedge CLK);
    model_step(st, ab, bv, s, c, rdy);
    #1;
  endtask

  // Optional start, then WIDTH bits with `gap` idle cycles before each bit.
  task automatic send_frame(input logic [WIDTH-1:0] val, input logic car,
                            input logic rdy, input int gap,
                            input bit with_start, input string name);
    if (with_start) begin cyc(1, 0, 0, 0, 0, rdy); chk_model(name); end
    for (int i = 0; i < WIDTH; i++) begin
      for (int g = 0; g < gap; g++) begin
        cyc(0, 0, 0, 1'($urandom), 1'($urandom), rdy);
        chk_model(name);
      end
      cyc(0, 0, 1, val[i], (i == WIDTH - 1) ? car : 1'b0, rdy);
      chk_model(name);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic st, ab, bv, s, c, rdy;
    logic [WIDTH-1:0] esum;
    logic ecar, evld, ebusy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic st, logic ab, logic bv, logic s, logic c,
                              logic rdy, logic [WIDTH-1:0] esum, logic ecar,
                              logic evld, logic ebusy);
    vec_t v;
    v.st = st; v.ab = ab; v.bv = bv; v.s = s; v.c = c; v.rdy = rdy;
    v.esum = esum; v.ecar = ecar; v.evld = evld; v.ebusy = ebusy;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [WIDTH-1:0] f;

    // Frame 0xA5, carry 1, consumer always ready
    f = 8'hA5;
    add(1, 0, 0, 0, 0, 1, 8'h00, 0, 0, 1);
    for (int i = 0; i < 7; i++) add(0, 0, 1, f[i], 0, 1, 8'h00, 0, 0, 1);
    add(0, 0, 1, f[7], 1, 1, 8'hA5, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 8'hA5, 1, 0, 0);
    add(0, 1, 1, 1, 1, 1, 8'hA5, 1, 0, 0);      // idle: no effect
    // Abort after 4 bits (abort together with a bit), then frame 0x3C
    add(1, 0, 0, 0, 0, 1, 8'hA5, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 1, 1, 8'hA5, 1, 0, 1);
    add(0, 1, 1, 1, 1, 1, 8'hA5, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 8'hA5, 1, 0, 0);
    f = 8'h3C;
    add(1, 0, 0, 0, 0, 0, 8'hA5, 1, 0, 1);
    for (int i = 0; i < 7; i++) add(i == 2, 0, 1, f[i], 1, 0, 8'hA5, 1, 0, 1);
    add(0, 0, 1, f[7], 0, 0, 8'h3C, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 8'h3C, 0, 1, 0);
    add(0, 1, 1, 1, 1, 0, 8'h3C, 0, 1, 0);      // abort/bit ignored in hold
    add(0, 0, 0, 0, 0, 1, 8'h3C, 0, 0, 0);

    // ---------------- reset ----------------
    RST = 1'b1;
    bus.start = 0; bus.abort = 0; bus.bit_vld = 0;
    bus.S_in = 0; bus.COUT_in = 0; bus.out_rdy = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", {21'd0, bus.SUM, bus.CARRY, bus.out_vld, bus.busy}, 32'd0);
    RST = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].st, tbl[i].ab, tbl[i].bv, tbl[i].s, tbl[i].c, tbl[i].rdy);
      check($sformatf("vec%0d", i),
            {21'd0, bus.SUM, bus.CARRY, bus.out_vld, bus.busy},
            {21'd0, tbl[i].esum, tbl[i].ecar, tbl[i].evld, tbl[i].ebusy});
    end

    // ---------------- gaps of 3 idle cycles between bits ----------------
    send_frame(8'hA5, 1'b1, 1'b1, 3, 1, "gap_frame");
    check("gap_sum", 32'(bus.SUM), 32'hA5);
    check("gap_vld", 32'(bus.out_vld), 32'd1);
    cyc(0, 0, 0, 0, 0, 1); chk_model("gap_done");

    // ---------------- hold for 5 cycles with bit_vld noise ----------------
    send_frame(8'hFF, 1'b0, 1'b0, 0, 1, "hold_frame");
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1'($urandom), 1, 1'($urandom), 1'($urandom), 0);
      check("hold_sum", {23'd0, bus.SUM, bus.CARRY}, {23'd0, 8'hFF, 1'b0});
      check("hold_vld", 32'(bus.out_vld), 32'd1);
    end
    cyc(0, 0, 0, 0, 0, 1); chk_model("hold_release");
    check("hold_release_vld", 32'(bus.out_vld), 32'd0);

    // ---------------- reset in the middle of a frame ----------------
    cyc(1, 0, 0, 0, 0, 1); chk_model("rst_frame");
    for (int i = 0; i < 6; i++) begin cyc(0, 0, 1, 1, 1, 1); chk_model("rst_frame"); end
    RST = 1'b1;
    #1;
    check("rst_async", {21'd0, bus.SUM, bus.CARRY, bus.out_vld, bus.busy}, 32'd0);
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin cyc(0, 0, 1, 1, 1, 1); chk_model("rst_after"); end
    send_frame(8'h81, 1'b1, 1'b0, 0, 1, "rst_next");
    check("rst_next_sum", 32'(bus.SUM), 32'h81);
    cyc(0, 0, 0, 0, 0, 1); chk_model("rst_next_done");

    // ---------------- HOLD -> COLLECT directly ----------------
    send_frame(8'h33, 1'b0, 1'b0, 0, 1, "b2b_first");
    cyc(1, 0, 0, 0, 0, 1);
    check("b2b_busy", {30'd0, bus.busy, bus.out_vld}, {30'd0, 1'b1, 1'b0});
    send_frame(8'h5A, 1'b1, 1'b0, 0, 0, "b2b_second");
    check("b2b_sum", {23'd0, bus.SUM, bus.out_vld}, {23'd0, 8'h5A, 1'b1});
    cyc(0, 0, 0, 0, 0, 1); chk_model("b2b_done");

    // ---------------- randomized traffic against the model ----------------
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        RST = 1'b1;
        #1;
        check("rnd_rst", {21'd0, bus.SUM, bus.CARRY, bus.out_vld, bus.busy}, 32'd0);
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
      end else begin
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 1) == 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) == 0);
        chk_model("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
